// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: payload + valid with stall pair handling,
// deferred squash of wrong-path items after a flush, and saturating perf counters.
module pipe_stage_reg #(
  parameter int                 DATA_W     = 32,
  parameter logic [DATA_W-1:0]  NOP_VALUE  = {DATA_W{1'b0}},
  parameter int                 KILL_DEPTH = 1,
  parameter int                 CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              stall_up,
  input  logic              stall_down,
  input  logic              flush,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              kill_pending,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  squash_cnt,
  output logic              protocol_err
);

  localparam logic [3:0]       KILL_INIT = 4'(KILL_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [3:0] kc;
  logic [3:0] kc_next;
  logic       do_bubble;
  logic       do_load;
  logic       do_squash;

  // A protocol violation (stall_down without stall_up) falls through to the
  // unstalled rules because only stall_up steers the decode below.
  always_comb begin
    do_bubble = 1'b0;
    do_load   = 1'b0;
    do_squash = 1'b0;
    kc_next   = kc;
    if (flush && stall_up) begin
      kc_next   = KILL_INIT;
      do_bubble = !stall_down;
    end else if (flush) begin
      kc_next   = 4'd0;
      do_bubble = 1'b1;
    end else if (stall_up) begin
      do_bubble = !stall_down;
    end else if (kc != 4'd0) begin
      kc_next   = kc - 4'd1;
      do_bubble = 1'b1;
      do_squash = 1'b1;
    end else begin
      do_load = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data     <= NOP_VALUE;
      out_valid    <= 1'b0;
      kc           <= 4'd0;
      bubble_cnt   <= '0;
      squash_cnt   <= '0;
      protocol_err <= 1'b0;
    end else begin
      kc <= kc_next;
      if (do_bubble) begin
        out_data  <= NOP_VALUE;
        out_valid <= 1'b0;
        if (bubble_cnt != CNT_MAX) bubble_cnt <= bubble_cnt + CNT_ONE;
      end else if (do_load) begin
        out_data  <= in_data;
        out_valid <= in_valid;
      end
      if (do_squash && (squash_cnt != CNT_MAX)) squash_cnt <= squash_cnt + CNT_ONE;
      if (stall_down && !stall_up) protocol_err <= 1'b1;
    end
  end

  assign kill_pending = (kc != 4'd0);

endmodule
